bilbo_bist_register: RTL
========================

// Module: bilbo_bist_register
// PURPOSE
//  Parametrised BILBO register with a built-in BIST session controller. Successor to the fixed
//  4/5-bit BILBO stages in the BILBO system. Adds: generic width/polynomial, PRPG vs MISR select,
//  gated test sessions of programmable length, and on-chip signature compare.
//  Sits between combinational blocks under test; scan chain via Si/So links registers.
// PARAMETERS
//  WIDTH  5         register width, >=2
//  POLY   5'b00101  feedback taps: fb = ^(Q & POLY); default fb = Q[0]^Q[2] (primitive, period 31)
//  SEED   5'b00001  non-zero value loaded by PRPG lock-up escape
//  CNT_W  8         session counter width; max session length 2**CNT_W-1 steps
// PORTS
//  Clk      in   1      rising-edge clock
//  Rst_n    in   1      synchronous active-low reset
//  B1, B2   in   1      mode select {B1,B2}: 11 NORMAL, 00 SCAN, 01 TEST, 10 CLEAR
//  Prpg     in   1      TEST sub-mode: 1 = PRPG (autonomous LFSR), 0 = MISR (compress DIn)
//  Si       in   1      scan serial in
//  So       out  1      scan serial out, = Q[0] (combinational from register)
//  DIn      in   WIDTH  parallel data / MISR input
//  DOut     out  WIDTH  register contents Q
//  Start    in   1      session start request (level, sampled per edge)
//  Cycles   in   CNT_W  session length in test steps, sampled at Start edge
//  Golden   in   WIDTH  expected signature, sampled at last step edge
//  Busy     out  1      session in progress
//  Done     out  1      one-cycle pulse: session finished
//  Pass     out  1      signature match result; valid from Done, held until next Start or reset
//  Abort    out  1      one-cycle pulse: session cancelled by mode change
// BEHAVIOUR
//  Reset (Rst_n=0 at edge): Q=0, Busy=0, Done=0, Pass=0, Abort=0, counter=0. Reset wins over all.
//  Register update per edge by mode:
//   NORMAL: Q <= DIn.   CLEAR: Q <= 0.
//   SCAN:   Q <= {Si, Q[WIDTH-1:1]}; LSB shifted out first on So.
//   TEST:   steps ONLY while Busy=1; otherwise Q holds.
//     PRPG step: Q <= (Q==0) ? SEED : {fb, Q[WIDTH-1:1]}.
//     MISR step: Q <= {fb, Q[WIDTH-1:1]} ^ DIn (no lock-up escape).
//  Session FSM, states IDLE / RUN:
//   IDLE: at edge with mode=TEST, Start=1, Cycles!=0: Busy<=1, cnt<=Cycles, Pass<=0, Q holds
//     (Start edge is not a step). Cycles==0: no RUN; next cycle Done=1, Pass=(Q==Golden).
//     Start in any other mode ignored.
//   RUN, mode=TEST: each edge one step, cnt--. Edge with cnt==1 is the last step:
//     Busy<=0, Done<=1, Pass<=(Q_next==Golden); back to IDLE.
//     Start while Busy ignored. Prpg/DIn may change per step; the value at each edge is used.
//   RUN, mode!=TEST: Busy<=0, Abort<=1, Done stays 0, Pass<=0; mode action applies same edge.
//  Latency: Start at edge E0 -> steps E1..EN (N=Cycles) -> Done/Pass visible after EN.
//  Done and Abort never both 1. Back-to-back: Start at the edge Done rises begins a new session.
//  Width rules: all Q arithmetic modulo WIDTH bits; cnt is unsigned CNT_W, never wraps (stops at 0).
// STRUCTURE
//  Shared header bilbo_defs.vh: mode encodings BILBO_NORMAL=2'b11, BILBO_SCAN=2'b00,
//   BILBO_TEST=2'b01, BILBO_CLEAR=2'b10; FSM state codes ST_IDLE, ST_RUN.
//  Sub-module bilbo_lfsr_core (WIDTH, POLY, SEED): datapath register + mode mux + step enable;
//   top level holds session FSM, counter, compare and pulse outputs.
// TESTING  (defaults WIDTH=5, POLY=5'b00101, SEED=5'b00001)
//  Scan: SCAN, Si = 0,1,1,0,1 over 5 edges -> DOut=5'b10110; 5 more edges -> So = 0,1,1,0,1.
//  PRPG: Q=5'b00001, TEST, Prpg=1, Start, Cycles=1 -> Q=5'b10000; Cycles=31 from 00001,
//   Golden=5'b00001 -> Done after 32 edges, Pass=1; Q=0 start -> first step Q=SEED.
//  MISR: CLEAR, then TEST, Prpg=0, DIn=5'b00011, Cycles=1, Golden=5'b00011 -> Pass=1;
//   Golden=5'b00010 -> Pass=0; Start edge alone leaves Q unchanged.
//  Abort: Cycles=10, switch to SCAN after step 4 -> Abort=1 one cycle, Busy=0, no Done, Pass=0.
//  Reset mid-session: Rst_n=0 at step 3 -> next cycle Q=0, Busy/Done/Pass/Abort=0; Start ignored
//   while Rst_n=0; Cycles=0 Start -> Done next cycle, Busy never 1.

Source files
------------

// File: rtl/bilbo_bist_register_pkg.sv
// Shared definitions for the BILBO BIST register: mode encodings and session FSM states.
package bilbo_bist_register_pkg;

  typedef enum logic [1:0] {
    BILBO_SCAN   = 2'b00,
    BILBO_TEST   = 2'b01,
    BILBO_CLEAR  = 2'b10,
    BILBO_NORMAL = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/bilbo_bist_register_if.sv
// Mode, scan, data and session signals of one BILBO register, grouped for port connection.
interface bilbo_bist_register_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             B1;
  logic             B2;
  logic             Prpg;
  logic             Si;
  logic             So;
  logic [WIDTH-1:0] DIn;
  logic [WIDTH-1:0] DOut;
  logic             Start;
  logic [CNT_W-1:0] Cycles;
  logic [WIDTH-1:0] Golden;
  logic             Busy;
  logic             Done;
  logic             Pass;
  logic             Abort;

  modport master (
    output B1, B2, Prpg, Si, DIn, Start, Cycles, Golden,
    input  So, DOut, Busy, Done, Pass, Abort
  );

  modport slave (
    input  B1, B2, Prpg, Si, DIn, Start, Cycles, Golden,
    output So, DOut, Busy, Done, Pass, Abort
  );
endinterface

// File: rtl/bilbo_bist_register_lfsr_core.sv
// BILBO datapath register: mode mux (normal/clear/scan/test) with gated PRPG or MISR step.
module bilbo_bist_register_lfsr_core
  import bilbo_bist_register_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  mode_e            mode_i,
  input  logic             prpg_i,
  input  logic             step_en_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_d_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shifted;
  logic             fb;

  always_comb begin
    fb      = ^(q_q & POLY);
    shifted = {fb, q_q[WIDTH-1:1]};
    q_d     = q_q;
    case (mode_i)
      BILBO_NORMAL: q_d = din_i;
      BILBO_CLEAR:  q_d = '0;
      BILBO_SCAN:   q_d = {si_i, q_q[WIDTH-1:1]};
      BILBO_TEST: begin
        // Outside a session the register holds in TEST mode.
        if (step_en_i) begin
          if (prpg_i) q_d = (q_q == '0) ? SEED : shifted;
          else        q_d = shifted ^ din_i;
        end
      end
      default:      q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q_o   = q_q;
  assign q_d_o = q_d;

endmodule

// File: rtl/bilbo_bist_register.sv
// BILBO register with BIST session controller: step counter, signature compare, Done/Abort pulses.
module bilbo_bist_register
  import bilbo_bist_register_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter logic [WIDTH-1:0] SEED  = 5'b00001,
  parameter int               CNT_W = 8
) (
  input logic                 Clk,
  input logic                 Rst_n,
  bilbo_bist_register_if.slave bus
);

  mode_e            mode;
  logic             step_en;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_d;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             abort_q;

  assign mode    = mode_e'({bus.B1, bus.B2});
  assign step_en = (state_q == ST_RUN) && (mode == BILBO_TEST);

  bilbo_bist_register_lfsr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk_i     (Clk),
    .rst_n_i   (Rst_n),
    .mode_i    (mode),
    .prpg_i    (bus.Prpg),
    .step_en_i (step_en),
    .si_i      (bus.Si),
    .din_i     (bus.DIn),
    .q_o       (q),
    .q_d_o     (q_d)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mode == BILBO_TEST && bus.Start) begin
            if (bus.Cycles != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= bus.Cycles;
              pass_q  <= 1'b0;
            end else begin
              // Zero-length session: compare the held register immediately.
              done_q <= 1'b1;
              pass_q <= (q == bus.Golden);
            end
          end
        end
        ST_RUN: begin
          if (mode == BILBO_TEST) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (q_d == bus.Golden);
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
            pass_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.So    = q[0];
  assign bus.DOut  = q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Pass  = pass_q;
  assign bus.Abort = abort_q;

endmodule
